// File: rtl/key_onehot_capture.sv
// Key front end for encoder83: synchronise, debounce and capture one key.
// Optional overflow flag output oOvf when KEY_OVF_EN is defined.
module key_onehot_capture #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] iKeys,
  input  logic       iAck,
  output logic [7:0] oData,
  output logic       oValid,
`ifdef KEY_OVF_EN
  output logic       oOvf,
`endif
  output logic       oMulti
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       s1_q, s2_q;
  logic [7:0]       deb_q, deb_d;
  logic [7:0]       debp_q;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [7:0]       ev;
  logic [7:0]       pick;
  logic             multi;
  logic [7:0]       data_q, data_d;
  logic [7:0]       cap_q, cap_d;
  logic             valid_q, valid_d;
  logic             multi_q, multi_d;

  // Highest set bit of v as a one-hot word (bit7 has priority)
  function automatic logic [7:0] hi_onehot(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Two-flop synchroniser on the raw key lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= iKeys;
      s2_q <= s1_q;
    end
  end

  // Per-bit debounce: accept a new level after DEB_CYCLES stable cycles
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounce state, counters and previous debounced level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q  <= '0;
      debp_q <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q  <= deb_d;
      debp_q <= deb_q;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign ev    = deb_q & ~debp_q;
  assign pick  = hi_onehot(ev);
  assign multi = |(ev & (ev - 8'd1));

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cap_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (|ev) state_d = HOLD;
      end
      HOLD: begin
        if (iAck) state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!(|(deb_q & cap_q))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values; cap_q remembers the key until it is released
  always_comb begin
    data_d  = data_q;
    cap_d   = cap_q;
    valid_d = valid_q;
    multi_d = multi_q;
    unique case (state_q)
      IDLE: begin
        if (|ev) begin
          data_d  = pick;
          cap_d   = pick;
          valid_d = 1'b1;
          multi_d = multi;
        end
      end
      HOLD: begin
        if (iAck) begin
          data_d  = '0;
          valid_d = 1'b0;
          multi_d = 1'b0;
        end
      end
      WAIT_REL: begin
        data_d  = '0;
        valid_d = 1'b0;
        multi_d = 1'b0;
      end
      default: begin
        data_d  = '0;
        cap_d   = '0;
        valid_d = 1'b0;
        multi_d = 1'b0;
      end
    endcase
  end

  assign oData  = data_q;
  assign oValid = valid_q;
  assign oMulti = multi_q;

`ifdef KEY_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a press while busy; set beats the ack clear
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == HOLD && iAck) ovf_d = 1'b0;
    if ((|ev) && state_q != IDLE) ovf_d = 1'b1;
  end

  // Overflow flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign oOvf = ovf_q;
`endif

endmodule

// File: tb/tb_key_onehot_capture.sv
// Directed bench for key_onehot_capture (DEB_CYCLES=4, latency 7 edges).
module tb_key_onehot_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] iKeys = 8'h00;
  logic       iAck = 1'b0;
  logic [7:0] oData;
  logic       oValid;
  logic       oMulti;
`ifdef KEY_OVF_EN
  logic       oOvf;
`endif

  int checks = 0;
  int errors = 0;

  key_onehot_capture #(.DEB_CYCLES(4), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .iKeys  (iKeys),
    .iAck   (iAck),
    .oData  (oData),
    .oValid (oValid),
`ifdef KEY_OVF_EN
    .oOvf   (oOvf),
`endif
    .oMulti (oMulti)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!$onehot0(oData)) begin
        errors++;
        $display("FAIL onehot: oData=%h not zero/one-hot", oData);
      end
      checks++;
      if (oValid !== (oData != 8'h00)) begin
        errors++;
        $display("FAIL valid_data: oValid=%b with oData=%h", oValid, oData);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    iKeys = 8'h00;
    step(2);
    checks++;
    if ({oValid, oData, oMulti} !== 10'b0) begin
      errors++;
      $display("FAIL reset: v=%b d=%h m=%b, want 0/00/0", oValid, oData, oMulti);
    end
`ifdef KEY_OVF_EN
    checks++;
    if (oOvf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: oOvf=%b, want 0", oOvf);
    end
`endif
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_glitch;
    iKeys = 8'h08;
    step(2);
    iKeys = 8'h00;
    step(12);
    checks++;
    if (oValid !== 1'b0 || oData !== 8'h00) begin
      errors++;
      $display("FAIL glitch: v=%b d=%h, want 0/00", oValid, oData);
    end
  endtask

  task automatic test_single;
    iKeys = 8'h01;
    step(6);
    checks++;
    if (oValid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: oValid=%b after 6 edges, want 0", oValid);
    end
    step(1);
    checks++;
    if (oValid !== 1'b1 || oData !== 8'h01 || oMulti !== 1'b0) begin
      errors++;
      $display("FAIL single_cap: v=%b d=%h m=%b, want 1/01/0", oValid, oData, oMulti);
    end
    step(3);
    checks++;
    if (oValid !== 1'b1 || oData !== 8'h01) begin
      errors++;
      $display("FAIL single_hold: v=%b d=%h, want 1/01", oValid, oData);
    end
    iAck = 1'b1;
    step(1);
    iAck = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oData !== 8'h00) begin
      errors++;
      $display("FAIL single_ack: v=%b d=%h, want 0/00", oValid, oData);
    end
    iKeys = 8'h00;
    step(10);
  endtask

  task automatic test_multi;
    iKeys = 8'h24;
    step(6);
    checks++;
    if (oValid !== 1'b0) begin
      errors++;
      $display("FAIL multi_early: oValid=%b, want 0", oValid);
    end
    iAck = 1'b1;
    step(1);
    checks++;
    if (oValid !== 1'b1 || oData !== 8'h20 || oMulti !== 1'b1) begin
      errors++;
      $display("FAIL multi_cap: v=%b d=%h m=%b, want 1/20/1", oValid, oData, oMulti);
    end
    step(1);
    iAck = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oData !== 8'h00 || oMulti !== 1'b0) begin
      errors++;
      $display("FAIL multi_ack: v=%b d=%h m=%b, want 0/00/0", oValid, oData, oMulti);
    end
    iKeys = 8'h00;
    step(10);
  endtask

  task automatic test_overflow;
    iKeys = 8'h01;
    step(7);
    checks++;
    if (oValid !== 1'b1 || oData !== 8'h01) begin
      errors++;
      $display("FAIL ovf_cap: v=%b d=%h, want 1/01", oValid, oData);
    end
`ifdef KEY_OVF_EN
    checks++;
    if (oOvf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pre: oOvf=%b, want 0", oOvf);
    end
`endif
    iKeys = 8'h81;
    step(10);
    checks++;
    if (oValid !== 1'b1 || oData !== 8'h01 || oMulti !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drop: v=%b d=%h m=%b, want 1/01/0", oValid, oData, oMulti);
    end
`ifdef KEY_OVF_EN
    checks++;
    if (oOvf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: oOvf=%b, want 1", oOvf);
    end
`endif
    iAck = 1'b1;
    step(1);
    iAck = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oData !== 8'h00) begin
      errors++;
      $display("FAIL ovf_ack: v=%b d=%h, want 0/00", oValid, oData);
    end
`ifdef KEY_OVF_EN
    checks++;
    if (oOvf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: oOvf=%b, want 0", oOvf);
    end
`endif
    iKeys = 8'h00;
    step(12);
  endtask

  task automatic test_wait_rel;
    iKeys = 8'h01;
    step(7);
    iAck = 1'b1;
    step(1);
    iAck = 1'b0;
    iKeys = 8'h02;
    step(12);
    checks++;
    if (oValid !== 1'b0 || oData !== 8'h00) begin
      errors++;
      $display("FAIL wr_drop: v=%b d=%h, want 0/00", oValid, oData);
    end
    iKeys = 8'h00;
    step(10);
    iKeys = 8'h01;
    step(7);
    checks++;
    if (oValid !== 1'b1 || oData !== 8'h01) begin
      errors++;
      $display("FAIL wr_recap: v=%b d=%h, want 1/01", oValid, oData);
    end
    iAck = 1'b1;
    step(1);
    iAck = 1'b0;
    iKeys = 8'h00;
    step(1);
    iKeys = 8'h02;
    step(6);
    checks++;
    if (oValid !== 1'b0) begin
      errors++;
      $display("FAIL wr_early: oValid=%b, want 0", oValid);
    end
    step(1);
    checks++;
    if (oValid !== 1'b1 || oData !== 8'h02) begin
      errors++;
      $display("FAIL wr_exit: v=%b d=%h, want 1/02", oValid, oData);
    end
    iAck = 1'b1;
    step(1);
    iAck = 1'b0;
    iKeys = 8'h00;
    step(12);
  endtask

  task automatic test_reset_hold;
    iKeys = 8'h04;
    step(7);
    checks++;
    if (oValid !== 1'b1 || oData !== 8'h04) begin
      errors++;
      $display("FAIL rh_cap: v=%b d=%h, want 1/04", oValid, oData);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({oValid, oData, oMulti} !== 10'b0) begin
      errors++;
      $display("FAIL rh_async: v=%b d=%h m=%b, want 0/00/0", oValid, oData, oMulti);
    end
    step(1);
    rst = 1'b0;
    step(6);
    checks++;
    if (oValid !== 1'b0) begin
      errors++;
      $display("FAIL rh_early: oValid=%b, want 0", oValid);
    end
    step(1);
    checks++;
    if (oValid !== 1'b1 || oData !== 8'h04) begin
      errors++;
      $display("FAIL rh_recap: v=%b d=%h, want 1/04", oValid, oData);
    end
    iAck = 1'b1;
    step(1);
    iAck = 1'b0;
    iKeys = 8'h00;
    step(12);
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_single();
    test_multi();
    test_overflow();
    test_wait_rel();
    test_reset_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
